// File: rtl/oclib_uart_rx.sv
// 8N1 UART receiver, oversampled by clock; byte out ~SyncCycles+HalfBit+9*CyclesPerBit+1 cycles after start edge.
// One-deep valid/ready holding register; a byte completing while it is full is dropped with an overflow pulse.
module oclib_uart_rx #(
    parameter int ClockHz    = 100_000_000,
    parameter int Baud       = 115200,
    parameter int SyncCycles = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rxData,
    output logic       rxValid,
    input  logic       rxReady,
    output logic       frameError,
    output logic       overflow
);

    localparam int CyclesPerBit = (ClockHz + Baud / 2) / Baud;
    localparam int HalfBit      = CyclesPerBit / 2;
    localparam int CntW         = $clog2(CyclesPerBit + 1);
    localparam logic [CntW-1:0] BitLoad  = CntW'(CyclesPerBit - 1);
    localparam logic [CntW-1:0] HalfLoad = CntW'(HalfBit - 1);

    if (CyclesPerBit < 8) begin : g_bad_rate
        $error("oclib_uart_rx: CyclesPerBit must be at least 8");
    end
    if (SyncCycles < 2) begin : g_bad_sync
        $error("oclib_uart_rx: SyncCycles must be at least 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_t;

    logic [SyncCycles-1:0] r_sync;
    logic [SyncCycles-1:0] r_fill;
    logic                  r_armed;
    logic                  w_rxS;

    state_t          r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_bitIdx, w_bitIdx_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            w_load, w_fe, w_ov, w_expire;

    logic [7:0] r_rxData;
    logic       r_rxValid, r_frameError, r_overflow;

    assign w_rxS  = r_sync[SyncCycles-1];
    assign rxData     = r_rxData;
    assign rxValid    = r_rxValid;
    assign frameError = r_frameError;
    assign overflow   = r_overflow;

    // r_fill marks when r_sync holds real samples; a start is only taken after a genuine high level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync  <= '1;
            r_fill  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_sync <= {r_sync[SyncCycles-2:0], rx};
            r_fill <= {r_fill[SyncCycles-2:0], 1'b1};
            if (r_fill[SyncCycles-1] && w_rxS) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_expire = (r_cnt == '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bitIdx_nxt = r_bitIdx;
        w_shift_nxt  = r_shift;
        w_load       = 1'b0;
        w_fe         = 1'b0;
        w_ov         = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_armed && !w_rxS) begin
                    w_cnt_nxt   = HalfLoad;
                    w_state_nxt = StStart;
                end
            end
            StStart: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end else if (w_rxS) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt    = BitLoad;
                    w_bitIdx_nxt = 3'd0;
                    w_state_nxt  = StData;
                end
            end
            StData: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end else begin
                    w_shift_nxt  = {w_rxS, r_shift[7:1]};
                    w_cnt_nxt    = BitLoad;
                    w_bitIdx_nxt = r_bitIdx + 3'd1;
                    if (r_bitIdx == 3'd7) begin
                        w_state_nxt = StStop;
                    end
                end
            end
            StStop: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end else if (w_rxS) begin
                    // A byte being drained this cycle frees the register for the new one.
                    if (!r_rxValid || rxReady) begin
                        w_load = 1'b1;
                    end else begin
                        w_ov = 1'b1;
                    end
                    w_state_nxt = StIdle;
                end else begin
                    w_fe        = 1'b1;
                    w_state_nxt = StBreak;
                end
            end
            StBreak: begin
                if (w_rxS) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_bitIdx     <= '0;
            r_shift      <= '0;
            r_rxData     <= '0;
            r_rxValid    <= 1'b0;
            r_frameError <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bitIdx     <= w_bitIdx_nxt;
            r_shift      <= w_shift_nxt;
            r_frameError <= w_fe;
            r_overflow   <= w_ov;
            if (w_load) begin
                r_rxData  <= r_shift;
                r_rxValid <= 1'b1;
            end else if (r_rxValid && rxReady) begin
                r_rxValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_oclib_uart_rx.sv
// Scoreboarded bench for oclib_uart_rx at 16 clocks per bit.
module tb_oclib_uart_rx;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;
    logic       frameError;
    logic       overflow;

    oclib_uart_rx #(
        .ClockHz   (1_600_000),
        .Baud      (100_000),
        .SyncCycles(3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .rxReady   (rxReady),
        .frameError(frameError),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_start = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int acc_cnt = 0;
    logic [7:0] exp_q[$];
    int acc_cyc[$];

    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: all DUT outputs sampled on the falling edge.
    always @(negedge clock) begin
        if (frameError) fe_cnt++;
        if (overflow) ov_cnt++;
        if (frameError || overflow) begin
            check("fe_ov_exclusive", {31'b0, frameError & overflow}, 32'd0);
            check("err_during_reset", {31'b0, reset}, 32'd0);
        end
        if (rxValid && rxReady) begin
            acc_cnt++;
            acc_cyc.push_back(cyc);
            check("sb_has_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) check("rx_byte", {24'b0, rxData}, {24'b0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        t_start = cyc;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
    endtask

    int fe0, ov0, a0, lat, n;
    logic [7:0] pat;

    initial begin
        rx = 1'b1;
        rxReady = 1'b1;
        reset = 1'b1;
        repeat (5) tick();
        check("rst_rxValid", {31'b0, rxValid}, 32'd0);
        check("rst_rxData", {24'b0, rxData}, 32'd0);
        check("rst_frameError", {31'b0, frameError}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        reset = 1'b0;
        idle(2 * CPB);

        // Single byte, immediate accept, latency
        fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_cnt;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        idle(2 * CPB);
        check("a5_accepts", acc_cnt - a0, 32'd1);
        lat = (acc_cyc.size() > 0) ? acc_cyc[$] - t_start : -1;
        check("a5_latency_in_window", {31'b0, (lat >= 155 && lat <= 157)}, 32'd1);
        check("a5_no_fe", fe_cnt - fe0, 32'd0);
        check("a5_no_ov", ov_cnt - ov0, 32'd0);

        // Back-to-back bytes, no idle gap
        a0 = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            pat = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h55;
            exp_q.push_back(pat);
            send_byte(pat, 1'b1);
        end
        idle(2 * CPB);
        check("b2b_accepts", acc_cnt - a0, 32'd3);
        n = acc_cyc.size();
        check("b2b_spacing_1", (n >= 3) ? acc_cyc[n-2] - acc_cyc[n-3] : 0, 32'd160);
        check("b2b_spacing_2", (n >= 3) ? acc_cyc[n-1] - acc_cyc[n-2] : 0, 32'd160);

        // Overflow: holding register full, second byte dropped
        fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_cnt;
        rxReady = 1'b0;
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        idle(CPB);
        check("ovf_first_valid", {31'b0, rxValid}, 32'd1);
        check("ovf_first_data", {24'b0, rxData}, 32'h12);
        send_byte(8'h34, 1'b1);
        idle(CPB);
        check("ovf_pulses", ov_cnt - ov0, 32'd1);
        check("ovf_no_fe", fe_cnt - fe0, 32'd0);
        check("ovf_held_valid", {31'b0, rxValid}, 32'd1);
        check("ovf_held_data", {24'b0, rxData}, 32'h12);
        rxReady = 1'b1;
        idle(4);
        check("ovf_drain_accepts", acc_cnt - a0, 32'd1);
        check("ovf_valid_dropped", {31'b0, rxValid}, 32'd0);
        idle(4 * CPB);
        check("ovf_no_late_byte", acc_cnt - a0, 32'd1);

        // Framing error followed by a long break
        fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_cnt;
        send_byte(8'h3C, 1'b0);
        repeat (40 * CPB) tick();
        idle(2 * CPB);
        check("brk_one_fe", fe_cnt - fe0, 32'd1);
        check("brk_no_byte", acc_cnt - a0, 32'd0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        idle(2 * CPB);
        check("brk_resend_accepts", acc_cnt - a0, 32'd1);
        check("brk_no_extra_fe", fe_cnt - fe0, 32'd1);

        // Short low glitch on idle line
        fe0 = fe_cnt; a0 = acc_cnt;
        rx = 1'b0;
        repeat (4) tick();
        idle(2 * CPB);
        check("glitch_no_byte", acc_cnt - a0, 32'd0);
        check("glitch_no_fe", fe_cnt - fe0, 32'd0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        idle(2 * CPB);
        check("glitch_then_81", acc_cnt - a0, 32'd1);

        // Reset in the middle of bit 4 of 0x77 (line then stays idle)
        fe0 = fe_cnt; ov0 = ov_cnt; a0 = acc_cnt;
        pat = 8'h77;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx = pat[i];
            repeat (CPB) tick();
        end
        rx = pat[4];
        repeat (CPB / 2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_rxValid", {31'b0, rxValid}, 32'd0);
        check("mid_rst_rxData", {24'b0, rxData}, 32'd0);
        check("mid_rst_fe", {31'b0, frameError}, 32'd0);
        check("mid_rst_ov", {31'b0, overflow}, 32'd0);
        idle(20 * CPB);
        check("mid_rst_77_lost", acc_cnt - a0, 32'd0);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 1'b1);
        idle(2 * CPB);
        check("mid_rst_c3", acc_cnt - a0, 32'd1);

        // Line held low across reset release
        fe0 = fe_cnt; a0 = acc_cnt;
        rx = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (20 * CPB) tick();
        check("low_rst_no_byte", acc_cnt - a0, 32'd0);
        check("low_rst_no_fe", fe_cnt - fe0, 32'd0);
        idle(2 * CPB);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        idle(2 * CPB);
        check("low_rst_then_5a", acc_cnt - a0, 32'd1);
        check("low_rst_fe_still_0", fe_cnt - fe0, 32'd0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
